// File: rtl/portin_pkt_buf.sv
// Serial input slice: deserialises a frame_n/valid_n/di lane into {address, payload}
// packets and queues complete packets in a show-ahead buffer drained by pop.
//
// state | meaning
// IDLE  | waiting for frame_n low
// ADDR  | shifting address bits, then padding
// DATA  | shifting payload bits, bubbles allowed
// DROP  | malformed packet, discarding until frame_n high
module portin_pkt_buf #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       frame_n,
    input  logic                       valid_n,
    input  logic                       di,
    input  logic                       pop,
    output logic                       vld,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          payload,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy,
    output logic                       err_frame,
    output logic                       err_ovf
);
    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int PKT_W   = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_sh, addr_sh_nxt;
    logic [DATA_W-1:0] pay_sh, pay_sh_nxt;
    logic              push_req, frame_bad;

    logic [PKT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              pop_acc, push_acc, ovf;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_sh <= '0;
            pay_sh  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_sh <= addr_sh_nxt;
            pay_sh  <= pay_sh_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_sh_nxt = addr_sh;
        pay_sh_nxt  = pay_sh;
        push_req    = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!frame_n) begin
                    if (valid_n) begin
                        addr_sh_nxt[0] = di;
                        cnt_nxt        = CNT_W'(1);
                        state_nxt      = ADDR;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            ADDR: begin
                if (frame_n) begin
                    frame_bad = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (valid_n) begin
                    // bits beyond ADDR_W are padding; cnt saturates at ADDR_W
                    if (cnt < ADDR_END) begin
                        for (int i = 0; i < ADDR_W; i++)
                            if (cnt == CNT_W'(i)) addr_sh_nxt[i] = di;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (cnt < ADDR_END) begin
                    frame_bad = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DROP;
                end else begin
                    pay_sh_nxt[0] = di;
                    cnt_nxt       = CNT_W'(1);
                    state_nxt     = DATA;
                end
            end
            DATA: begin
                case ({frame_n, valid_n})
                    2'b00: begin
                        if (cnt < DATA_END) begin
                            for (int i = 0; i < DATA_W; i++)
                                if (cnt == CNT_W'(i)) pay_sh_nxt[i] = di;
                            cnt_nxt = cnt + CNT_W'(1);
                        end else begin
                            frame_bad = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = DROP;
                        end
                    end
                    2'b01: ;
                    2'b10: begin
                        if (cnt == DATA_END) begin
                            pay_sh_nxt[DATA_W-1] = di;
                            push_req = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                    default: begin
                        frame_bad = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                endcase
            end
            DROP: begin
                if (frame_n) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        vld     = (level != '0);
        addr    = '0;
        payload = '0;
        if (vld) {addr, payload} = mem[rd_ptr];
    end

    // a push into a full buffer still fits when the head leaves on the same edge
    assign pop_acc  = pop && vld;
    assign push_acc = push_req && ((level < LVL_W'(DEPTH)) || pop_acc);
    assign ovf      = push_req && !push_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            err_frame <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_acc, pop_acc})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            err_frame <= frame_bad;
            err_ovf   <= ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (push_acc) mem[wr_ptr] <= {addr_sh, pay_sh_nxt};
    end

endmodule

// File: doc/portin_pkt_buf.md
Name: portin_pkt_buf

Overview:
- Parametrised successor to the router's serial input slice.
- Deserialises one frame_n/valid_n/di serial lane into {address, payload} packets with configurable widths.
- Detects framing errors and buffers up to DEPTH complete packets in a show-ahead FIFO; the downstream arbiter drains it with a pop handshake.
- Sits between the serial pin and the switching fabric; replaces the single-packet register and its clear logic.

Parameters:
- ADDR_W, 4, address bits per packet (1..8).
- DATA_W, 32, payload bits per packet (2..64).
- DEPTH, 4, packet buffer entries (2..16, any integer; pointers wrap modulo DEPTH).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_n  in  1  low for the duration of a packet.
- valid_n  in  1  low while di carries payload bits.
- di  in  1  serial data, LSB first.
- pop  in  1  consume the head packet; ignored when vld=0.
- vld  out  1  buffer non-empty; head packet presented.
- addr  out  ADDR_W  head packet address; 0 when vld=0.
- payload  out  DATA_W  head packet payload; 0 when vld=0.
- level  out  clog2(DEPTH+1)  number of stored packets.
- busy  out  1  receiver not in IDLE.
- err_frame  out  1  one-cycle pulse on a malformed packet.
- err_ovf  out  1  one-cycle pulse when a complete packet is dropped because the buffer is full.

Behaviour:
- Reset (async, reset=1): state=IDLE, bit counter=0, FIFO empty, all outputs 0, pointers 0.
- All inputs are sampled on the rising clock edge. Receiver FSM states: IDLE, ADDR, DATA, DROP.
- IDLE:
  - frame_n=0, valid_n=1: addr_sh[0]<=di, cnt<=1, go to ADDR.
  - frame_n=0, valid_n=0: pulse err_frame, go to DROP (packet has no address).
- ADDR:
  - frame_n=0, valid_n=1: if cnt<ADDR_W, addr_sh[cnt]<=di and cnt++. Otherwise the bit is padding: ignored, cnt saturates.
  - frame_n=0, valid_n=0: if cnt<ADDR_W, pulse err_frame and go to DROP. Otherwise pay_sh[0]<=di, cnt<=1, go to DATA.
  - frame_n=1: pulse err_frame, go to IDLE.
- DATA:
  - frame_n=0, valid_n=0: if cnt<DATA_W-1, pay_sh[cnt]<=di and cnt++. Otherwise (too long) pulse err_frame and go to DROP.
  - frame_n=0, valid_n=1: bubble; hold state and cnt.
  - frame_n=1, valid_n=0: final bit. If cnt==DATA_W-1, pay_sh[cnt]<=di and push {addr_sh, final payload}. Otherwise (short) pulse err_frame with no push. Go to IDLE.
  - frame_n=1, valid_n=1: truncated; pulse err_frame, go to IDLE.
- DROP: ignore di; go to IDLE on the first sampled frame_n=1. No further error pulses while in DROP.
- busy=1 in ADDR, DATA and DROP.
- Push rules:
  - Push is accepted if level<DEPTH, or if level==DEPTH and a pop is accepted in the same cycle.
  - Otherwise the packet is discarded, err_ovf pulses and level is unchanged.
- Pop rules:
  - pop with vld=1 advances the read pointer at the clock edge.
  - pop with vld=0 has no effect.
  - Simultaneous push and pop leaves level unchanged.
- Latency: a pushed packet appears on vld/addr/payload the cycle after the final-bit edge, including into an empty buffer. It is held stable until popped.
- level, vld, addr and payload are registered or derived from registered state; there is no combinational path from di or frame_n.
- Back-to-back packets are allowed: IDLE accepts a new address bit on the cycle immediately after the final bit.
- Reset asserted mid-packet or with a non-empty buffer discards everything immediately. No error pulses are generated by reset.

Test Plan:
- Basic packet: ADDR_W=4, DATA_W=32. Send addr 4'hA (LSB first), 1 pad bit, payload 32'hDEADBEEF -> one cycle after the final bit: vld=1, addr=4'hA, payload=32'hDEADBEEF, level=1. After pop: vld=0, addr=0, payload=0.
- Fill and overflow: DEPTH=4, no pops, send 5 packets with addr 1..5 -> level=4, err_ovf pulses once at the 5th final bit. Popping yields addr 1,2,3,4 in order.
- Simultaneous push/pop at full: level=4, pop asserted on the final-bit cycle of packet 6 -> no err_ovf, level stays 4, tail entry is packet 6.
- Framing errors, each -> exactly one err_frame pulse, no push, FSM returns to IDLE by the next frame_n=1:
  - valid_n low after only 2 address bits;
  - frame_n high after 20 payload bits;
  - 33 payload bits with frame_n still low.
- Bubble tolerance: valid_n high for 3 cycles mid-payload (frame_n low) -> packet received intact with the correct payload, no error.
- Reset mid-packet: assert reset at payload bit 10 with level=2 -> level=0, vld=0, busy=0. The next well-formed packet is received normally.
